// File: rtl/cache_arb_pkg.sv
// Shared definitions for the cache channel arbiters: FSM state type and ID width helper.
package cache_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } arb_state_t;

    // Width of a grant index for n requesters; never narrower than one bit.
    function automatic int unsigned id_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_priority_select.sv
// Combinational round-robin selector: finds the first set request bit
// scanning upward from (pointer+1) mod N_REQ with wrap-around.
module rr_priority_select #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned ID_W  = 2
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [ID_W-1:0]  i_ptr,
    output logic [ID_W-1:0]  o_idx,
    output logic             o_found
);

    int unsigned w_dist;
    int unsigned w_best;

    // Pick the requester with the smallest rotational distance past the pointer.
    always_comb begin
        o_idx   = '0;
        o_found = 1'b0;
        w_dist  = 0;
        w_best  = N_REQ;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            // Distance 0 is the slot right after the pointer; pointer is always < N_REQ.
            w_dist = (i + N_REQ - 1 - 32'(i_ptr)) % N_REQ;
            if (i_req[i] && (w_dist < w_best)) begin
                w_best  = w_dist;
                o_idx   = ID_W'(i);
                o_found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/write_channel_arbiter.sv
// Round-robin arbiter sharing one cache write channel between N_REQ requesters.
// One transaction in flight; single-cycle m_valid pulse with registered payload
// held until the downstream completion handshake.
module write_channel_arbiter
    import cache_arb_pkg::*;
#(
    parameter int unsigned N_REQ  = 4,
    parameter int unsigned ADDR_W = 30,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned NBYTES = DATA_W / 8,
    parameter int unsigned ID_W   = id_width(N_REQ)
) (
    input  logic                     ap_clk,
    input  logic                     reset,
    input  logic [N_REQ-1:0]         s_valid,
    input  logic [N_REQ*ADDR_W-1:0]  s_addr,
    input  logic [N_REQ*DATA_W-1:0]  s_wdata,
    input  logic [N_REQ*NBYTES-1:0]  s_wstrb,
    output logic [N_REQ-1:0]         s_ready,
    output logic                     m_valid,
    output logic [ADDR_W-1:0]        m_addr,
    output logic [DATA_W-1:0]        m_wdata,
    output logic [NBYTES-1:0]        m_wstrb,
    input  logic                     m_ready,
    output logic [ID_W-1:0]          grant_id,
    output logic                     busy
);

    arb_state_t          r_state;
    arb_state_t          w_next;
    logic [ID_W-1:0]     r_grant;
    logic [ID_W-1:0]     r_ptr;
    logic [ID_W-1:0]     w_idx;
    logic                w_found;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [NBYTES-1:0]   r_wstrb;
    logic [ADDR_W-1:0]   w_sel_addr;
    logic [DATA_W-1:0]   w_sel_wdata;
    logic [NBYTES-1:0]   w_sel_wstrb;

    rr_priority_select #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_sel (
        .i_req   (s_valid),
        .i_ptr   (r_ptr),
        .o_idx   (w_idx),
        .o_found (w_found)
    );

    // Route the winning requester's payload slice toward the capture registers.
    always_comb begin
        w_sel_addr  = '0;
        w_sel_wdata = '0;
        w_sel_wstrb = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (w_idx == ID_W'(i)) begin
                w_sel_addr  = s_addr[i*ADDR_W +: ADDR_W];
                w_sel_wdata = s_wdata[i*DATA_W +: DATA_W];
                w_sel_wstrb = s_wstrb[i*NBYTES +: NBYTES];
            end
        end
    end

    // State register.
    always_ff @(posedge ap_clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state: one ISSUE cycle, then wait for completion; m_ready only counts in WAIT.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (w_found) w_next = ST_ISSUE;
            ST_ISSUE: w_next = ST_WAIT;
            ST_WAIT:  if (m_ready) w_next = ST_DONE;
            ST_DONE:  w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    // Grant, payload capture at arbitration time, and pointer update on completion.
    always_ff @(posedge ap_clk or posedge reset) begin
        if (reset) begin
            r_grant <= '0;
            r_ptr   <= ID_W'(N_REQ - 1);
            r_addr  <= '0;
            r_wdata <= '0;
            r_wstrb <= '0;
        end else begin
            if ((r_state == ST_IDLE) && w_found) begin
                r_grant <= w_idx;
                r_addr  <= w_sel_addr;
                r_wdata <= w_sel_wdata;
                r_wstrb <= w_sel_wstrb;
            end
            if (r_state == ST_DONE) begin
                r_ptr <= r_grant;
            end
        end
    end

    // State-decoded outputs: valid pulse in ISSUE, one-hot completion in DONE.
    always_comb begin
        m_valid = (r_state == ST_ISSUE);
        busy    = (r_state == ST_ISSUE) || (r_state == ST_WAIT);
        s_ready = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            s_ready[i] = (r_state == ST_DONE) && (r_grant == ID_W'(i));
        end
    end

    assign m_addr   = r_addr;
    assign m_wdata  = r_wdata;
    assign m_wstrb  = r_wstrb;
    assign grant_id = r_grant;

endmodule

// File: tb/tb_write_channel_arbiter.sv
// Self-checking bench for write_channel_arbiter: directed scenarios plus a
// randomized run, checked against a transaction-level round-robin model.
module tb_write_channel_arbiter;

    localparam int N  = 4;
    localparam int AW = 30;
    localparam int DW = 32;
    localparam int NB = 4;
    localparam int IW = 2;

    logic              ap_clk = 1'b0;
    logic              reset;
    logic [N-1:0]      s_valid;
    logic [N*AW-1:0]   s_addr;
    logic [N*DW-1:0]   s_wdata;
    logic [N*NB-1:0]   s_wstrb;
    logic [N-1:0]      s_ready;
    logic              m_valid;
    logic [AW-1:0]     m_addr;
    logic [DW-1:0]     m_wdata;
    logic [NB-1:0]     m_wstrb;
    logic              m_ready;
    logic [IW-1:0]     grant_id;
    logic              busy;

    // Requester-side view: one valid bit and one payload per requester.
    logic [N-1:0]      sv;
    logic [AW-1:0]     addr_a [N];
    logic [DW-1:0]     data_a [N];
    logic [NB-1:0]     strb_a [N];

    int n_assert = 0;
    int n_fail   = 0;
    int m_last   = N - 1;
    logic prev_mv = 1'b0;

    write_channel_arbiter #(
        .N_REQ  (N),
        .ADDR_W (AW),
        .DATA_W (DW)
    ) dut (
        .ap_clk   (ap_clk),
        .reset    (reset),
        .s_valid  (s_valid),
        .s_addr   (s_addr),
        .s_wdata  (s_wdata),
        .s_wstrb  (s_wstrb),
        .s_ready  (s_ready),
        .m_valid  (m_valid),
        .m_addr   (m_addr),
        .m_wdata  (m_wdata),
        .m_wstrb  (m_wstrb),
        .m_ready  (m_ready),
        .grant_id (grant_id),
        .busy     (busy)
    );

    always #5 ap_clk = ~ap_clk;

    always_comb begin
        s_valid = sv;
        for (int i = 0; i < N; i++) begin
            s_addr[i*AW +: AW]  = addr_a[i];
            s_wdata[i*DW +: DW] = data_a[i];
            s_wstrb[i*NB +: NB] = strb_a[i];
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference rule: first requesting index after the last completed grant, wrapping.
    function automatic int rr_pick(input logic [N-1:0] req, input int last);
        for (int k = 1; k <= N; k++) begin
            if (req[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    // Protocol invariants, checked every cycle outside reset.
    always @(negedge ap_clk) begin
        if (!reset) begin
            chk("mvalid_consecutive", 64'(prev_mv & m_valid), 64'd0);
            chk("sready_onehot0", 64'($onehot0(s_ready)), 64'd1);
        end
        prev_mv <= m_valid;
    end

    // One transaction from an IDLE negedge with requests already driven.
    // mode: 0 requester drops on s_ready, 1 alter payload in WAIT,
    //       2 drop s_valid in WAIT, 3 keep requesting after completion.
    task automatic txn(input int mode, input int d, input bit early);
        int e;
        logic [AW-1:0] ea;
        logic [DW-1:0] ed;
        logic [NB-1:0] es;
        e = rr_pick(sv, m_last);
        if (e < 0) begin
            chk("no_request_model", 64'd1, 64'd0);
            return;
        end
        ea = addr_a[e];
        ed = data_a[e];
        es = strb_a[e];
        m_ready = early;
        chk("idle_mvalid", 64'(m_valid), 64'd0);
        chk("idle_busy", 64'(busy), 64'd0);
        @(negedge ap_clk);
        chk("issue_mvalid", 64'(m_valid), 64'd1);
        chk("issue_grant", 64'(grant_id), 64'(e));
        chk("issue_addr", 64'(m_addr), 64'(ea));
        chk("issue_wdata", 64'(m_wdata), 64'(ed));
        chk("issue_wstrb", 64'(m_wstrb), 64'(es));
        chk("issue_busy", 64'(busy), 64'd1);
        chk("issue_sready", 64'(s_ready), 64'd0);
        for (int j = 0; j < d; j++) begin
            @(negedge ap_clk);
            chk("wait_mvalid", 64'(m_valid), 64'd0);
            chk("wait_sready", 64'(s_ready), 64'd0);
            chk("wait_busy", 64'(busy), 64'd1);
            chk("wait_addr", 64'(m_addr), 64'(ea));
            chk("wait_wdata", 64'(m_wdata), 64'(ed));
            if (j == 0 && mode == 1) begin
                addr_a[e] = 30'h200;
                data_a[e] = ~data_a[e];
                strb_a[e] = ~strb_a[e];
            end
            if (j == 0 && mode == 2) sv[e] = 1'b0;
            if (j == d - 1) m_ready = 1'b1;
        end
        @(negedge ap_clk);
        chk("done_sready", 64'(s_ready), 64'(1) << e);
        chk("done_busy", 64'(busy), 64'd0);
        chk("done_mvalid", 64'(m_valid), 64'd0);
        chk("done_addr", 64'(m_addr), 64'(ea));
        chk("done_wstrb", 64'(m_wstrb), 64'(es));
        m_ready = 1'b0;
        if (mode != 3) sv[e] = 1'b0;
        m_last = e;
        @(negedge ap_clk);
        chk("gap_sready", 64'(s_ready), 64'd0);
        chk("gap_busy", 64'(busy), 64'd0);
        chk("gap_mvalid", 64'(m_valid), 64'd0);
    endtask

    initial begin
        int newr;
        int pick;
        bit early;
        reset   = 1'b1;
        m_ready = 1'b0;
        sv      = '0;
        for (int i = 0; i < N; i++) begin
            addr_a[i] = '0;
            data_a[i] = '0;
            strb_a[i] = '0;
        end
        repeat (2) @(negedge ap_clk);
        chk("rst_mvalid", 64'(m_valid), 64'd0);
        chk("rst_sready", 64'(s_ready), 64'd0);
        chk("rst_grant", 64'(grant_id), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_addr", 64'(m_addr), 64'd0);
        chk("rst_wdata", 64'(m_wdata), 64'd0);
        chk("rst_wstrb", 64'(m_wstrb), 64'd0);
        reset = 1'b0;
        @(negedge ap_clk);

        // Single request, payload altered while waiting, m_ready 5 cycles after pulse.
        sv        = 4'b0001;
        addr_a[0] = 30'h100;
        data_a[0] = 32'hDEADBEEF;
        strb_a[0] = 4'hF;
        txn(1, 5, 1'b0);

        // All requesters continuously active.
        sv = 4'b1111;
        for (int i = 0; i < N; i++) begin
            addr_a[i] = AW'(32'h1000 + i);
            data_a[i] = 32'hA5A50000 + i;
            strb_a[i] = NB'(i + 1);
        end
        for (int t = 0; t < 5; t++) txn(3, 2, 1'b0);
        sv = '0;

        // Grant to 2 with 0 and 3 pending: 3 must precede 0.
        m_last = m_last;
        sv = 4'b0010;
        txn(0, 1, 1'b0);
        sv = 4'b1101;
        chk("wrap_model_first", 64'(rr_pick(sv, m_last)), 64'd2);
        txn(0, 2, 1'b0);
        chk("wrap_model_second", 64'(rr_pick(sv, m_last)), 64'd3);
        txn(0, 1, 1'b0);
        txn(0, 3, 1'b0);

        // m_ready held high from IDLE: completion only after one WAIT cycle.
        sv = 4'b0100;
        txn(0, 1, 1'b1);

        // Granted requester withdraws mid-transaction; completion still signalled.
        sv = 4'b1000;
        txn(2, 3, 1'b0);

        // Reset during WAIT abandons the transfer and restarts from requester 0.
        sv = 4'b0010;
        txn(0, 1, 1'b0);
        sv = 4'b1101;
        @(negedge ap_clk);
        chk("pre_rst_issue_grant", 64'(grant_id), 64'd2);
        @(negedge ap_clk);
        chk("pre_rst_wait_busy", 64'(busy), 64'd1);
        reset = 1'b1;
        #1;
        chk("midrst_mvalid", 64'(m_valid), 64'd0);
        chk("midrst_sready", 64'(s_ready), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_grant", 64'(grant_id), 64'd0);
        chk("midrst_addr", 64'(m_addr), 64'd0);
        m_last = N - 1;
        @(negedge ap_clk);
        reset = 1'b0;
        txn(0, 2, 1'b0);

        // Randomized traffic with pending requests carried between transactions.
        for (int it = 0; it < 30; it++) begin
            newr = int'($urandom_range(0, 15));
            for (int i = 0; i < N; i++) begin
                if (!sv[i] && newr[i]) begin
                    sv[i]     = 1'b1;
                    addr_a[i] = AW'($urandom);
                    data_a[i] = $urandom;
                    strb_a[i] = NB'($urandom);
                end
            end
            if (sv == '0) begin
                pick         = int'($urandom_range(0, N - 1));
                sv[pick]     = 1'b1;
                addr_a[pick] = AW'($urandom);
                data_a[pick] = $urandom;
                strb_a[pick] = NB'($urandom);
            end
            early = 1'($urandom_range(0, 1));
            txn(0, early ? 1 : int'($urandom_range(1, 4)), early);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/write_channel_arbiter.md
Name: write_channel_arbiter

Overview:
- Shares one cache write channel (IOb-style valid/addr/wdata/wstrb/ready, AXI master behind it) between N_REQ requesters, e.g. a write-through buffer, a write-back victim path and a DMA flush port.
- Round-robin arbitration with one transaction in flight; the grant is held until the downstream completion handshake.
- Issues a single-cycle valid pulse, because the downstream channel re-launches on a held valid. Payload is registered so it stays stable for the whole AXI AW/W/B sequence.

Parameters:
- N_REQ, 4, number of requesters (>=2).
- ADDR_W, 30, width of the word-address slice forwarded downstream.
- DATA_W, 32, write data width.
- NBYTES, DATA_W/8, strobe width.
- ID_W, $clog2(N_REQ), grant index width.

Ports:
- ap_clk  in  1  clock.
- reset  in  1  asynchronous, active-high.
- s_valid  in  N_REQ  per-requester request; held until the matching s_ready.
- s_addr  in  N_REQ*ADDR_W  packed addresses; requester i uses bits [i*ADDR_W +: ADDR_W].
- s_wdata  in  N_REQ*DATA_W  packed write data.
- s_wstrb  in  N_REQ*NBYTES  packed byte strobes.
- s_ready  out  N_REQ  one-hot completion pulse to the granted requester.
- m_valid  out  1  downstream request pulse.
- m_addr  out  ADDR_W  registered address.
- m_wdata  out  DATA_W  registered data.
- m_wstrb  out  NBYTES  registered strobes.
- m_ready  in  1  downstream ready/completion.
- grant_id  out  ID_W  current or last grant index.
- busy  out  1  high in ISSUE or WAIT.

Behaviour:
- Reset values: state=IDLE; m_valid=0; m_addr, m_wdata, m_wstrb=0; s_ready=0; grant_id=0; busy=0; rr pointer=N_REQ-1, so requester 0 wins first.
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - If any s_valid is set, pick the first set bit scanning from (pointer+1) mod N_REQ upward, with wrap-around.
  - Register grant_id and capture that requester's addr, wdata and wstrb into the m_* registers. Go to ISSUE.
- ISSUE: m_valid=1 for exactly one cycle; m_ready is ignored in this state. Go to WAIT unconditionally.
- WAIT:
  - m_valid=0; m_* payload held.
  - On m_ready=1, go to DONE.
  - Downstream error retries are internal to the channel and only delay m_ready.
- DONE:
  - s_ready[grant_id]=1 for one cycle; pointer<=grant_id. Return to IDLE.
  - Arbitration for the next request starts in IDLE on the following cycle.
- Latency:
  - Request-to-m_valid is 2 cycles (IDLE sample, then ISSUE).
  - m_ready-to-s_ready is 1 cycle.
  - Minimum idle gap between back-to-back grants is 1 cycle.
- Grant stability:
  - If the granted requester drops s_valid mid-transaction (protocol violation), the transaction still completes from the captured payload, and s_ready still pulses.
  - Input changes after capture never alter m_*.
- Simultaneous requests: strictly round-robin. A requester waits at most N_REQ-1 other transactions.
- m_ready high in IDLE or DONE is ignored.
- Reset mid-operation: all state returns to reset values immediately; any in-flight downstream transaction is abandoned. The downstream channel shares the same reset.
- N_REQ not a power of two: the pointer wraps mod N_REQ; grant_id never exceeds N_REQ-1.
- Invariants: s_ready is one-hot or zero; m_valid is never high in two consecutive cycles.

Decomposition:
- Shared package, cache_arb_pkg:
  - state encoding localparams (IDLE=2'd0, ISSUE=2'd1, WAIT=2'd2, DONE=2'd3);
  - a clog2-safe ID width helper (minimum 1).
- Sub-module rr_priority_select (combinational):
  - inputs: request vector, pointer;
  - outputs: winner index and a found flag.
  - Instantiated once; reusable by the read-channel arbiter.

Test Plan:
- Single request: s_valid=4'b0001, addr=0x100, wdata=0xDEADBEEF, wstrb=4'hF. Required: m_valid pulses 2 cycles later with those values; m_ready asserted 5 cycles after the pulse; s_ready=4'b0001 exactly one cycle later.
- All four requesting continuously. Required: grant order 0,1,2,3,0; each s_ready one-hot; m_valid never high in two consecutive cycles.
- After a grant to 2, requests 0 and 3 pending. Required: 3 is granted before 0 (wrap-around).
- Payload stability: change s_addr[0] to 0x200 during WAIT. Required: m_addr stays 0x100 until DONE.
- m_ready held high through IDLE and ISSUE. Required: no premature completion; DONE occurs only after WAIT observes m_ready.
- Assert reset during WAIT. Required: m_valid=0 and s_ready=0 immediately; the next grant after reset goes to requester 0.
